// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame FSM states, {I,Q} word unpacking and bit reversal.
// Helpers work on wide fixed-size vectors; callers slice the low bits they need.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

  // Sign-extended I component of a {I,Q} word with dw-bit components.
  function automatic logic [31:0] i_of(input logic [63:0] word, input int dw);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 32; k++) r[k] = (k < dw) ? word[dw + k] : word[2*dw - 1];
    return r;
  endfunction

  function automatic logic [31:0] q_of(input logic [63:0] word, input int dw);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 32; k++) r[k] = (k < dw) ? word[k] : word[dw - 1];
    return r;
  endfunction

  function automatic logic [31:0] bit_reverse(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 32; k++) if (k < w) r[w - 1 - k] = v[k];
    return r;
  endfunction

endpackage

// File: rtl/mag_sq_pipe.sv
// I*I+Q*Q in two registered stages (squares, then sum); 2-cycle latency.
// No backpressure: a new beat may enter every cycle, sideband travels with the data.
module mag_sq_pipe
  import fft_pkg::*;
#(
  parameter int  DATA_WIDTH = 8,
  parameter int  ADDR_WIDTH = 6,
  localparam int MAG_WIDTH  = 2*DATA_WIDTH + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_vld,
  input  logic [2*DATA_WIDTH-1:0] in_dat,
  input  logic                    in_last,
  input  logic                    in_err,
  input  logic [ADDR_WIDTH-1:0]   in_idx,
  output logic                    out_vld,
  output logic [MAG_WIDTH-1:0]    out_mag,
  output logic                    out_last,
  output logic                    out_err,
  output logic [ADDR_WIDTH-1:0]   out_idx
);
  localparam int SQ_WIDTH = 2*DATA_WIDTH;

  logic [31:0]                i_ext, q_ext;
  logic signed [SQ_WIDTH-1:0] i_w, q_w;
  logic                       unused_ext;

  logic [SQ_WIDTH-1:0]   ii_q, ii_d, qq_q, qq_d;
  logic                  vld1_q, vld1_d, last1_q, last1_d, err1_q, err1_d;
  logic [ADDR_WIDTH-1:0] idx1_q, idx1_d;
  logic [MAG_WIDTH-1:0]  mag_q, mag_d;
  logic                  vld2_q, vld2_d, last2_q, last2_d, err2_q, err2_d;
  logic [ADDR_WIDTH-1:0] idx2_q, idx2_d;

  always_comb begin
    i_ext = i_of(64'(in_dat), DATA_WIDTH);
    q_ext = q_of(64'(in_dat), DATA_WIDTH);
    // Low SQ_WIDTH bits of the extension already hold the sign-extended component.
    i_w   = i_ext[SQ_WIDTH-1:0];
    q_w   = q_ext[SQ_WIDTH-1:0];
    ii_d  = i_w * i_w;
    qq_d  = q_w * q_w;
    vld1_d  = in_vld;
    last1_d = in_last;
    err1_d  = in_err;
    idx1_d  = in_idx;
    mag_d   = {1'b0, ii_q} + {1'b0, qq_q};
    vld2_d  = vld1_q;
    last2_d = last1_q;
    err2_d  = err1_q;
    idx2_d  = idx1_q;
  end

  assign unused_ext = &{1'b0, i_ext[31:SQ_WIDTH], q_ext[31:SQ_WIDTH]};

  always_ff @(posedge clk) begin
    if (rst) begin
      ii_q <= '0; qq_q <= '0; vld1_q <= 1'b0; last1_q <= 1'b0; err1_q <= 1'b0; idx1_q <= '0;
      mag_q <= '0; vld2_q <= 1'b0; last2_q <= 1'b0; err2_q <= 1'b0; idx2_q <= '0;
    end else begin
      ii_q <= ii_d; qq_q <= qq_d; vld1_q <= vld1_d; last1_q <= last1_d; err1_q <= err1_d;
      idx1_q <= idx1_d;
      mag_q <= mag_d; vld2_q <= vld2_d; last2_q <= last2_d; err2_q <= err2_d; idx2_q <= idx2_d;
    end
  end

  assign out_vld  = vld2_q;
  assign out_mag  = mag_q;
  assign out_last = last2_q;
  assign out_err  = err2_q;
  assign out_idx  = idx2_q;

endmodule

// File: rtl/fft_mag_peak.sv
// Per-bin |X|^2 stream (2 cycles after input) plus per-frame peak report 1 cycle after last mag.
// No backpressure: every in_valid beat is accepted; frames may run back to back.
module fft_mag_peak
  import fft_pkg::*;
#(
  parameter int  N           = 64,
  parameter int  DATA_WIDTH  = 8,
  parameter int  ADDR_WIDTH  = $clog2(N),
  parameter int  BIT_REVERSE = 0,
  parameter int  SKIP_DC     = 1,
  localparam int MAG_WIDTH   = 2*DATA_WIDTH + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [2*DATA_WIDTH-1:0] in_data,
  input  logic                    in_last,
  input  logic [MAG_WIDTH-1:0]    threshold,
  output logic                    mag_valid,
  output logic [MAG_WIDTH-1:0]    mag_data,
  output logic [ADDR_WIDTH-1:0]   mag_index,
  output logic                    mag_last,
  output logic                    peak_valid,
  output logic [ADDR_WIDTH-1:0]   peak_index,
  output logic [MAG_WIDTH-1:0]    peak_mag,
  output logic                    peak_hit,
  output logic                    frame_err
);
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d, nat_idx;
  logic [MAG_WIDTH-1:0]  thr_pend_q, thr_pend_d, thr_act_q, thr_act_d, thr_use;
  logic                  at_end, eff_last, beat_err, unused_rev;
  logic [31:0]           rev;

  logic                  s2_vld, s2_last, s2_err;
  logic [MAG_WIDTH-1:0]  s2_mag;
  logic [ADDR_WIDTH-1:0] s2_idx;

  state_t                state_q, state_d;
  logic [MAG_WIDTH-1:0]  max_q, max_d, max_base;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d, idx_base;
  logic                  have_q, have_d, have_base, frame_start, eligible, load;
  logic                  peak_valid_q, peak_valid_d, peak_hit_q, peak_hit_d;
  logic                  frame_err_q, frame_err_d;
  logic [ADDR_WIDTH-1:0] peak_index_q, peak_index_d;
  logic [MAG_WIDTH-1:0]  peak_mag_q, peak_mag_d;

  // Input side: the bin counter closes a frame on in_last or on reaching N-1.
  always_comb begin
    at_end     = (cnt_q == ADDR_WIDTH'(N - 1));
    eff_last   = in_last || at_end;
    beat_err   = eff_last && !(in_last && at_end);
    rev        = bit_reverse(32'(cnt_q), ADDR_WIDTH);
    nat_idx    = (BIT_REVERSE != 0) ? rev[ADDR_WIDTH-1:0] : cnt_q;
    cnt_d      = cnt_q;
    thr_pend_d = thr_pend_q;
    if (in_valid) begin
      if (cnt_q == '0) thr_pend_d = threshold;
      cnt_d = eff_last ? '0 : cnt_q + ADDR_WIDTH'(1);
    end
  end

  assign unused_rev = &{1'b0, rev[31:ADDR_WIDTH]};

  mag_sq_pipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mag_sq_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_valid),
    .in_dat  (in_data),
    .in_last (eff_last),
    .in_err  (beat_err),
    .in_idx  (nat_idx),
    .out_vld (s2_vld),
    .out_mag (s2_mag),
    .out_last(s2_last),
    .out_err (s2_err),
    .out_idx (s2_idx)
  );

  // Peak search runs on stage-2 beats; any beat outside ACCUM opens a new frame.
  always_comb begin
    state_d      = state_q;
    max_d        = max_q;
    idx_d        = idx_q;
    have_d       = have_q;
    thr_act_d    = thr_act_q;
    peak_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    peak_index_d = peak_index_q;
    peak_mag_d   = peak_mag_q;
    peak_hit_d   = peak_hit_q;
    frame_start  = s2_vld && (state_q != ACCUM);
    have_base    = frame_start ? 1'b0 : have_q;
    max_base     = frame_start ? '0 : max_q;
    idx_base     = frame_start ? '0 : idx_q;
    thr_use      = frame_start ? thr_pend_q : thr_act_q;
    eligible     = !((SKIP_DC != 0) && (s2_idx == '0));
    load         = s2_vld && eligible && (!have_base || (s2_mag > max_base));
    if (state_q == REPORT) state_d = IDLE;
    if (s2_vld) begin
      thr_act_d = thr_use;
      have_d    = have_base || load;
      max_d     = load ? s2_mag : max_base;
      idx_d     = load ? s2_idx : idx_base;
      state_d   = ACCUM;
      if (s2_last) begin
        state_d      = REPORT;
        peak_valid_d = 1'b1;
        peak_index_d = idx_d;
        peak_mag_d   = max_d;
        peak_hit_d   = max_d > thr_use;
        frame_err_d  = s2_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0; thr_pend_q <= '0; thr_act_q <= '0;
      state_q <= IDLE; max_q <= '0; idx_q <= '0; have_q <= 1'b0;
      peak_valid_q <= 1'b0; peak_index_q <= '0; peak_mag_q <= '0;
      peak_hit_q <= 1'b0; frame_err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d; thr_pend_q <= thr_pend_d; thr_act_q <= thr_act_d;
      state_q <= state_d; max_q <= max_d; idx_q <= idx_d; have_q <= have_d;
      peak_valid_q <= peak_valid_d; peak_index_q <= peak_index_d; peak_mag_q <= peak_mag_d;
      peak_hit_q <= peak_hit_d; frame_err_q <= frame_err_d;
    end
  end

  assign mag_valid  = s2_vld;
  assign mag_data   = s2_mag;
  assign mag_index  = s2_idx;
  assign mag_last   = s2_last;
  assign peak_valid = peak_valid_q;
  assign peak_index = peak_index_q;
  assign peak_mag   = peak_mag_q;
  assign peak_hit   = peak_hit_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_fft_mag_peak.sv
// Bench: three configurations share one stimulus stream and are scored against a frame model.
module tb_fft_mag_peak;
  localparam int N = 64;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_last;
  logic [15:0] in_data;
  logic [16:0] threshold;

  wire [2:0]       mag_valid, mag_last, peak_valid, peak_hit, frame_err;
  wire [2:0][16:0] mag_data, peak_mag;
  wire [2:0][5:0]  mag_index, peak_index;

  always #5 clk = ~clk;

  // g=0: natural order, skip DC; g=1: bit-reversed order, skip DC; g=2: natural order, DC searched
  for (genvar g = 0; g < 3; g++) begin : g_dut
    fft_mag_peak #(
      .N(N), .DATA_WIDTH(8), .BIT_REVERSE(g == 1 ? 1 : 0), .SKIP_DC(g == 2 ? 0 : 1)
    ) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .threshold(threshold),
      .mag_valid(mag_valid[g]), .mag_data(mag_data[g]), .mag_index(mag_index[g]),
      .mag_last(mag_last[g]), .peak_valid(peak_valid[g]), .peak_index(peak_index[g]),
      .peak_mag(peak_mag[g]), .peak_hit(peak_hit[g]), .frame_err(frame_err[g])
    );
  end

  typedef struct packed {
    int             due;
    logic [16:0]    mag;
    logic [2:0][5:0] idx;
    logic           last;
  } mexp_t;

  typedef struct packed {
    int               due;
    logic [2:0][5:0]  idx;
    logic [2:0][16:0] mag;
    logic [2:0]       hit;
    logic             err;
  } pexp_t;

  typedef struct packed {
    int a_pos; int a_i; int a_q; int b_pos; int b_i; int dc_i; int thr;
    logic [2:0][5:0]  e_idx;
    logic [2:0][16:0] e_mag;
    logic [2:0]       e_hit;
  } vec_t;

  mexp_t magq[$];
  pexp_t repq[$];
  int    fr_mag[$];
  int    fr_thr;
  int    cyc, total, bad;
  int    rep_cnt[3], base_cnt[3];
  logic [5:0]  cap_idx[3];
  logic [16:0] cap_mag[3];
  logic        cap_hit[3], cap_err[3];
  vec_t  vt[5];

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0d, want %0d", nm, d, act, exp);
    end
  endtask

  function automatic int nat(input int c, input int raw);
    int r;
    r = 0;
    if (c != 1) return raw;
    for (int b = 0; b < 6; b++) if (((raw >> b) & 1) != 0) r += 1 << (5 - b);
    return r;
  endfunction

  function automatic logic [15:0] pk(input int i, input int q);
    logic [31:0] a, b;
    a = i;
    b = q;
    return {a[7:0], b[7:0]};
  endfunction

  function automatic vec_t mk(input int ap, input int ai, input int aq, input int bp,
                              input int bi, input int dc, input int th,
                              input int i0, input int m0, input int h0,
                              input int i1, input int m1, input int h1,
                              input int i2, input int m2, input int h2);
    vec_t v;
    v.a_pos = ap; v.a_i = ai; v.a_q = aq; v.b_pos = bp; v.b_i = bi; v.dc_i = dc; v.thr = th;
    v.e_idx[0] = 6'(i0); v.e_mag[0] = 17'(m0); v.e_hit[0] = (h0 != 0);
    v.e_idx[1] = 6'(i1); v.e_mag[1] = 17'(m1); v.e_hit[1] = (h1 != 0);
    v.e_idx[2] = 6'(i2); v.e_mag[2] = 17'(m2); v.e_hit[2] = (h2 != 0);
    return v;
  endfunction

  // Reference: a frame is a list of magnitudes; the peak is found by scanning that list.
  task automatic model_beat(input logic [15:0] d, input logic l);
    int    iv, qv, m, raw, best, bi;
    bit    found;
    mexp_t me;
    pexp_t pe;
    iv  = int'($signed(d[15:8]));
    qv  = int'($signed(d[7:0]));
    m   = iv*iv + qv*qv;
    raw = fr_mag.size();
    if (raw == 0) fr_thr = int'(threshold);
    me.due  = cyc + 1;
    me.mag  = 17'(m);
    me.last = l || (raw == N - 1);
    for (int c = 0; c < 3; c++) me.idx[c] = 6'(nat(c, raw));
    magq.push_back(me);
    fr_mag.push_back(m);
    if (me.last) begin
      pe.due = cyc + 2;
      pe.err = !(l && raw == N - 1);
      for (int c = 0; c < 3; c++) begin
        found = 0; best = 0; bi = 0;
        for (int j = 0; j < fr_mag.size(); j++) begin
          if (c != 2 && nat(c, j) == 0) continue;
          if (!found || fr_mag[j] > best) begin
            best = fr_mag[j]; bi = nat(c, j); found = 1;
          end
        end
        pe.idx[c] = 6'(bi);
        pe.mag[c] = 17'(best);
        pe.hit[c] = best > fr_thr;
      end
      repq.push_back(pe);
      fr_mag.delete();
    end
  endtask

  task automatic check_outputs();
    logic  mdue, pdue;
    mexp_t md;
    pexp_t pd;
    mdue = 1'b0;
    pdue = 1'b0;
    if (magq.size() > 0) mdue = (magq[0].due == cyc);
    if (repq.size() > 0) pdue = (repq[0].due == cyc);
    if (mdue) md = magq[0];
    if (pdue) pd = repq[0];
    for (int d = 0; d < 3; d++) begin
      chk("mag_valid", d, 32'(mag_valid[d]), 32'(mdue));
      if (mdue) begin
        chk("mag_data", d, 32'(mag_data[d]), 32'(md.mag));
        chk("mag_index", d, 32'(mag_index[d]), 32'(md.idx[d]));
        chk("mag_last", d, 32'(mag_last[d]), 32'(md.last));
      end
      chk("peak_valid", d, 32'(peak_valid[d]), 32'(pdue));
      chk("frame_err", d, 32'(frame_err[d]), pdue ? 32'(pd.err) : 32'd0);
      if (pdue) begin
        chk("peak_index", d, 32'(peak_index[d]), 32'(pd.idx[d]));
        chk("peak_mag", d, 32'(peak_mag[d]), 32'(pd.mag[d]));
        chk("peak_hit", d, 32'(peak_hit[d]), 32'(pd.hit[d]));
      end
      if (peak_valid[d] === 1'b1) begin
        rep_cnt[d]++;
        cap_idx[d] = peak_index[d];
        cap_mag[d] = peak_mag[d];
        cap_hit[d] = peak_hit[d];
        cap_err[d] = frame_err[d];
      end
    end
    if (mdue) md = magq.pop_front();
    if (pdue) pd = repq.pop_front();
  endtask

  task automatic step(input logic v, input logic [15:0] d, input logic l);
    in_valid = v;
    in_data  = d;
    in_last  = l;
    @(posedge clk);
    cyc++;
    if (rst) begin
      magq.delete();
      repq.delete();
      fr_mag.delete();
    end else if (v) begin
      model_beat(d, l);
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 16'h0, 1'b0);
  endtask

  task automatic snap();
    for (int d = 0; d < 3; d++) base_cnt[d] = rep_cnt[d];
  endtask

  task automatic expect_reports(input string nm, input int n, input logic err);
    for (int d = 0; d < 3; d++) begin
      chk({nm, "_count"}, d, 32'(rep_cnt[d] - base_cnt[d]), 32'(n));
      if (n > 0) chk({nm, "_err"}, d, 32'(cap_err[d]), 32'(err));
    end
  endtask

  task automatic run_frame(input vec_t v);
    int i, q;
    for (int b = 0; b < N; b++) begin
      i = (b == v.a_pos) ? v.a_i : (b == v.b_pos) ? v.b_i : (b == 0) ? v.dc_i : 0;
      q = (b == v.a_pos) ? v.a_q : 0;
      step(1'b1, pk(i, q), b == N - 1);
    end
  endtask

  initial begin
    int len;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; threshold = '0;
    total = 0; bad = 0; cyc = 0;
    for (int d = 0; d < 3; d++) rep_cnt[d] = 0;

    vt[0] = mk(5, 100, 0, -1, 0, 0, 9999,    5, 10000, 1,  40, 10000, 1,  5, 10000, 1);
    vt[1] = mk(5, 100, 0, -1, 0, 0, 10000,   5, 10000, 0,  40, 10000, 0,  5, 10000, 0);
    vt[2] = mk(1, -128, -128, -1, 0, 0, 0,   1, 32768, 1,  32, 32768, 1,  1, 32768, 1);
    vt[3] = mk(3, 50, 0, 40, 50, 100, 5000,  3, 2500, 0,   48, 2500, 0,   0, 10000, 1);
    vt[4] = mk(-1, 0, 0, -1, 0, 0, 0,        1, 0, 0,      32, 0, 0,      0, 0, 0);

    @(negedge clk);
    idle(3);
    for (int d = 0; d < 3; d++) begin
      chk("rst_mag_data", d, 32'(mag_data[d]), 32'd0);
      chk("rst_mag_index", d, 32'(mag_index[d]), 32'd0);
      chk("rst_mag_last", d, 32'(mag_last[d]), 32'd0);
      chk("rst_peak_index", d, 32'(peak_index[d]), 32'd0);
      chk("rst_peak_mag", d, 32'(peak_mag[d]), 32'd0);
      chk("rst_peak_hit", d, 32'(peak_hit[d]), 32'd0);
    end
    rst = 1'b0;
    idle(2);

    // Directed single frames from the vector table
    for (int k = 0; k < 5; k++) begin
      threshold = 17'(vt[k].thr);
      snap();
      run_frame(vt[k]);
      idle(3);
      expect_reports("tbl", 1, 1'b0);
      for (int d = 0; d < 3; d++) begin
        chk("tbl_idx", d, 32'(cap_idx[d]), 32'(vt[k].e_idx[d]));
        chk("tbl_mag", d, 32'(cap_mag[d]), 32'(vt[k].e_mag[d]));
        chk("tbl_hit", d, 32'(cap_hit[d]), 32'(vt[k].e_hit[d]));
      end
    end

    // Short frame: in_last on the 10th bin
    threshold = 17'd100;
    snap();
    for (int b = 0; b < 10; b++) step(1'b1, pk(b == 7 ? 30 : 0, 0), b == 9);
    idle(3);
    expect_reports("short", 1, 1'b1);
    chk("short_idx", 0, 32'(cap_idx[0]), 32'd7);
    chk("short_mag", 0, 32'(cap_mag[0]), 32'd900);

    // 70 bins, in_last only on the 70th: forced close at 64, then a 6-bin frame
    snap();
    for (int b = 0; b < 70; b++) step(1'b1, 16'($urandom), b == 69);
    idle(3);
    expect_reports("long", 2, 1'b1);

    // Back-to-back frames with random gaps inside each frame
    threshold = 17'd8000;
    snap();
    for (int f = 0; f < 2; f++)
      for (int b = 0; b < N; b++) begin
        if (b != 0) while ($urandom_range(0, 3) == 0) step(1'b0, 16'($urandom), 1'b0);
        step(1'b1, 16'($urandom), b == N - 1);
      end
    idle(3);
    expect_reports("b2b", 2, 1'b0);

    // Reset at bin 30 aborts the frame silently
    snap();
    for (int b = 0; b < 30; b++) step(1'b1, 16'($urandom), 1'b0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(3);
    expect_reports("abort", 0, 1'b0);
    threshold = 17'(vt[0].thr);
    snap();
    run_frame(vt[0]);
    idle(3);
    expect_reports("after_rst", 1, 1'b0);
    chk("after_rst_idx", 0, 32'(cap_idx[0]), 32'd5);

    // Random frame lengths, data and thresholds against the model
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 70);
      threshold = 17'($urandom_range(0, 40000));
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 4) == 0) step(1'b0, 16'h0, 1'b0);
        step(1'b1, 16'($urandom), b == len - 1);
      end
      idle(3);
    end

    idle(4);
    chk("queues_drained", 0, 32'(magq.size() + repq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
